grid_mover: RTL and testbench
=============================

GRID_MOVER -- requirements
Module: grid_mover

Interface
REQ-001 Parameter COORD_W, default 10, coordinate width in bits.
REQ-002 Parameter STEP, default 32, pixels moved per accepted step.
REQ-003 Parameter X_MAX, default 608, largest legal x; Y_MAX, default 448, largest legal y; minimum for both is 0.
REQ-004 Parameter X_START, default 320; Y_START, default 448; spawn position.
REQ-005 Parameter REPEAT_DELAY, default 25_000_000, held-button cycles before the first auto-repeat.
REQ-006 Parameter REPEAT_RATE, default 6_250_000, cycles between subsequent auto-repeats.
REQ-007 clk  input  1  system clock.
REQ-008 reset  input  1  asynchronous, active-high reset.
REQ-009 btn  input  4  raw direction buttons: [0] up, [1] down, [2] left, [3] right.
REQ-010 respawn  input  1  synchronous single-cycle request to return to spawn.
REQ-011 pos_x  output  COORD_W  current x, registered.
REQ-012 pos_y  output  COORD_W  current y, registered.
REQ-013 step_pulse  output  1  one-cycle strobe on every position change.
REQ-014 blocked_pulse  output  1  one-cycle strobe when a step is refused at a boundary.

Function
REQ-015 Each btn bit SHALL pass through its own debouncer; all logic below uses debounced bits db[3:0].
REQ-016 Screen convention: up = y-STEP, down = y+STEP, left = x-STEP, right = x+STEP.
REQ-017 FSM states: IDLE, HOLD_DELAY, HOLD_REPEAT.
REQ-018 IDLE: on any db bit high, select one direction by priority up>down>left>right, issue a step that cycle, latch dir, load counter, go HOLD_DELAY.
REQ-019 HOLD_DELAY: counter counts REPEAT_DELAY cycles; at expiry issue a step in latched dir, reload with REPEAT_RATE, go HOLD_REPEAT.
REQ-020 HOLD_REPEAT: issue a step every REPEAT_RATE cycles while latched dir stays high.
REQ-021 In HOLD_* states, latched dir low SHALL return FSM to IDLE the next cycle with no step; other buttons are ignored while latched dir is held.
REQ-022 Step legality: up needs y>=STEP, down needs y+STEP<=Y_MAX, left needs x>=STEP, right needs x+STEP<=X_MAX; compare at COORD_W+1 bits, no wrap-around.
REQ-023 Legal step: position updates on the issue cycle, step_pulse high the following cycle (aligned with new position); latency from debounced edge to new pos = 1 cycle.
REQ-024 Illegal step: position unchanged, blocked_pulse high one cycle, FSM timing proceeds as if the step occurred.
REQ-025 respawn high: pos := (X_START, Y_START), FSM := IDLE, counter cleared, no pulses; respawn overrides any step in the same cycle.
REQ-026 After respawn with a button still held, a new step SHALL require that button to go low then high (held bits masked until released).
REQ-027 Only one axis changes per step; diagonal moves SHALL never occur.

Reset
REQ-028 reset SHALL asynchronously force pos_x=X_START, pos_y=Y_START, FSM=IDLE, counter=0, step_pulse=0, blocked_pulse=0, respawn mask cleared.
REQ-029 Buttons held across reset release SHALL be treated as fresh presses (no mask after reset).
REQ-030 Parameters SHALL satisfy X_START<=X_MAX, Y_START<=Y_MAX, both multiples of STEP; elaboration-time check.

Structure
REQ-031 FSM state encoding and direction index constants (DIR_UP..DIR_RIGHT) SHALL live in shared package game_pkg.
REQ-032 Debouncing SHALL reuse the existing debounce_switch sub-module, four instances; no other sub-modules.
REQ-033 Repeat counter width SHALL be $clog2 of max(REPEAT_DELAY, REPEAT_RATE)+1.

Verification (bench uses REPEAT_DELAY=8, REPEAT_RATE=4, debouncer bypass/short)
REQ-034 Reset then tap up once at (320,448) -> pos (320,416), single step_pulse.
REQ-035 Hold right from (320,448) for 20 cycles after debounce -> steps at t=0, 8, 12, 16, 20: x=352,384,416,448,480.
REQ-036 At (608,0) press right, then up -> no movement, two blocked_pulse strobes.
REQ-037 Press up and left same cycle at (320,448) -> only y changes to 416; releasing up while left held -> no step until left released and re-pressed.
REQ-038 Hold down mid-repeat, assert respawn -> pos (320,448) that cycle+1, no further steps until down released and pressed.
REQ-039 Assert reset mid-HOLD_REPEAT -> immediate return to (320,448), pulses low, FSM IDLE.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types for the grid game: mover FSM states, direction indices and the
// fixed-priority direction picker.
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_HOLD_DELAY  = 2'd1,
    ST_HOLD_REPEAT = 2'd2
  } mover_state_t;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  // Priority up > down > left > right; caller guarantees at least one bit set.
  function automatic logic [1:0] pick_dir(input logic [3:0] b);
    if (b[DIR_UP])        return DIR_UP;
    else if (b[DIR_DOWN]) return DIR_DOWN;
    else if (b[DIR_LEFT]) return DIR_LEFT;
    else                  return DIR_RIGHT;
  endfunction

endpackage

// File: rtl/debounce_switch.sv
// Single-switch debouncer: 2-flop synchroniser plus a stability counter.
// CYCLES == 0 passes the raw switch straight through.
module debounce_switch #(
  parameter int CYCLES = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic i_sw,
  output logic o_db
);

  if (CYCLES == 0) begin : g_bypass
    logic w_unused_clk_rst;
    assign w_unused_clk_rst = clk ^ reset;
    assign o_db = i_sw;
  end else begin : g_filter
    localparam int CW = (CYCLES > 1) ? $clog2(CYCLES + 1) : 1;
    logic [1:0]    r_sync;
    logic          r_state;
    logic [CW-1:0] r_cnt;

    // Output flips only after the synchronised input differs for CYCLES clocks.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_sync  <= '0;
        r_state <= 1'b0;
        r_cnt   <= '0;
      end else begin
        r_sync <= {r_sync[0], i_sw};
        if (r_sync[1] == r_state) begin
          r_cnt <= '0;
        end else if (r_cnt == CW'(CYCLES - 1)) begin
          r_state <= r_sync[1];
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end

    assign o_db = r_state;
  end

endmodule

// File: rtl/grid_mover.sv
// Grid cursor mover: debounced direction buttons drive single-axis STEP moves
// with press, hold-delay and auto-repeat timing, clamped to the play field.
module grid_mover
  import game_pkg::*;
#(
  parameter int COORD_W         = 10,
  parameter int STEP            = 32,
  parameter int X_MAX           = 608,
  parameter int Y_MAX           = 448,
  parameter int X_START         = 320,
  parameter int Y_START         = 448,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_RATE     = 6_250_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         i_btn,
  input  logic               i_respawn,
  output logic [COORD_W-1:0] o_pos_x,
  output logic [COORD_W-1:0] o_pos_y,
  output logic               o_step_pulse,
  output logic               o_blocked_pulse
);

  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CNT_W   = $clog2(RPT_MAX + 1);

  localparam logic [COORD_W:0] STEP_E = (COORD_W + 1)'(STEP);
  localparam logic [COORD_W:0] XMAX_E = (COORD_W + 1)'(X_MAX);
  localparam logic [COORD_W:0] YMAX_E = (COORD_W + 1)'(Y_MAX);

  if (STEP < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1 ||
      X_MAX >= (1 << COORD_W) || Y_MAX >= (1 << COORD_W) ||
      X_START > X_MAX || Y_START > Y_MAX ||
      (X_START % STEP) != 0 || (Y_START % STEP) != 0) begin : g_bad_params
    $error("grid_mover: illegal parameter combination");
  end

  logic [3:0] w_db;

  for (genvar i = 0; i < 4; i++) begin : g_db
    debounce_switch #(.CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk   (clk),
      .reset (reset),
      .i_sw  (i_btn[i]),
      .o_db  (w_db[i])
    );
  end

  mover_state_t       r_state;
  logic [1:0]         r_dir;
  logic [CNT_W-1:0]   r_cnt;
  logic [3:0]         r_mask;
  logic [COORD_W-1:0] r_pos_x, r_pos_y;
  logic               r_step_pulse, r_blocked_pulse;

  // Buttons still held from before a respawn or a released hold are not fresh presses.
  logic [3:0] w_avail;
  assign w_avail = w_db & ~r_mask;

  logic               w_issue;
  logic [1:0]         w_dir;
  logic               w_legal;
  logic [COORD_W-1:0] w_nx, w_ny;
  logic [COORD_W:0]   w_x_e, w_y_e;

  assign w_x_e = {1'b0, r_pos_x};
  assign w_y_e = {1'b0, r_pos_y};

  always_comb begin
    w_issue = 1'b0;
    w_dir   = r_dir;
    unique case (r_state)
      ST_IDLE: begin
        if (|w_avail) begin
          w_issue = 1'b1;
          w_dir   = pick_dir(w_avail);
        end
      end
      ST_HOLD_DELAY, ST_HOLD_REPEAT: begin
        if (w_db[r_dir] && r_cnt == '0) w_issue = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_legal = 1'b0;
    w_nx    = r_pos_x;
    w_ny    = r_pos_y;
    unique case (w_dir)
      DIR_UP: begin
        w_legal = (w_y_e >= STEP_E);
        w_ny    = r_pos_y - COORD_W'(STEP);
      end
      DIR_DOWN: begin
        w_legal = (w_y_e + STEP_E <= YMAX_E);
        w_ny    = r_pos_y + COORD_W'(STEP);
      end
      DIR_LEFT: begin
        w_legal = (w_x_e >= STEP_E);
        w_nx    = r_pos_x - COORD_W'(STEP);
      end
      default: begin
        w_legal = (w_x_e + STEP_E <= XMAX_E);
        w_nx    = r_pos_x + COORD_W'(STEP);
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= ST_IDLE;
      r_dir           <= DIR_UP;
      r_cnt           <= '0;
      r_mask          <= '0;
      r_pos_x         <= COORD_W'(X_START);
      r_pos_y         <= COORD_W'(Y_START);
      r_step_pulse    <= 1'b0;
      r_blocked_pulse <= 1'b0;
    end else begin
      r_step_pulse    <= 1'b0;
      r_blocked_pulse <= 1'b0;
      r_mask          <= r_mask & w_db;
      if (i_respawn) begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
        r_mask  <= w_db;
        r_pos_x <= COORD_W'(X_START);
        r_pos_y <= COORD_W'(Y_START);
      end else begin
        if (w_issue) begin
          if (w_legal) begin
            r_pos_x      <= w_nx;
            r_pos_y      <= w_ny;
            r_step_pulse <= 1'b1;
          end else begin
            r_blocked_pulse <= 1'b1;
          end
        end
        unique case (r_state)
          ST_IDLE: begin
            if (|w_avail) begin
              r_dir   <= w_dir;
              r_cnt   <= CNT_W'(REPEAT_DELAY - 1);
              r_state <= ST_HOLD_DELAY;
            end
          end
          ST_HOLD_DELAY, ST_HOLD_REPEAT: begin
            // Releasing the latched button masks whatever else is still held.
            if (!w_db[r_dir]) begin
              r_state <= ST_IDLE;
              r_cnt   <= '0;
              r_mask  <= w_db;
            end else if (r_cnt == '0) begin
              r_cnt   <= CNT_W'(REPEAT_RATE - 1);
              r_state <= ST_HOLD_REPEAT;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign o_pos_x         = r_pos_x;
  assign o_pos_y         = r_pos_y;
  assign o_step_pulse    = r_step_pulse;
  assign o_blocked_pulse = r_blocked_pulse;

endmodule

// File: tb/tb_grid_mover.sv
// Scoreboard bench for grid_mover: stimulus queues expected pulses (kind,
// position, cycle); a negedge monitor pops and compares every pulse it sees.
module tb_grid_mover;

  localparam int CW = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [3:0]    btn = 4'b0;
  logic          respawn = 1'b0;
  logic [CW-1:0] pos_x, pos_y;
  logic          step_p, blk_p;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    bit blk;
    int x;
    int y;
    int c;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  grid_mover #(
    .COORD_W(CW), .STEP(32), .X_MAX(608), .Y_MAX(448),
    .X_START(320), .Y_START(448),
    .REPEAT_DELAY(8), .REPEAT_RATE(4), .DEBOUNCE_CYCLES(0)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .i_btn           (btn),
    .i_respawn       (respawn),
    .o_pos_x         (pos_x),
    .o_pos_y         (pos_y),
    .o_step_pulse    (step_p),
    .o_blocked_pulse (blk_p)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Monitor: every pulse must match the head of the scoreboard exactly.
  initial forever begin
    @(negedge clk);
    if (!reset && (step_p || blk_p)) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_pulse: got step=%0b blocked=%0b pos=(%0d,%0d) cyc=%0d, required no pulse",
                 step_p, blk_p, pos_x, pos_y, cyc);
      end else begin
        mon_e = sb.pop_front();
        if (step_p != !mon_e.blk || blk_p != mon_e.blk ||
            int'(pos_x) != mon_e.x || int'(pos_y) != mon_e.y || cyc != mon_e.c) begin
          n_err++;
          $display("FAIL pulse: got step=%0b blocked=%0b pos=(%0d,%0d) cyc=%0d, required step=%0b blocked=%0b pos=(%0d,%0d) cyc=%0d",
                   step_p, blk_p, pos_x, pos_y, cyc,
                   !mon_e.blk, mon_e.blk, mon_e.x, mon_e.y, mon_e.c);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_ev(input bit blk, input int x, input int y, input int dc);
    exp_t e;
    e.blk = blk; e.x = x; e.y = y; e.c = cyc + dc;
    sb.push_back(e);
  endtask

  task automatic check_quiet(input string name, input int x, input int y);
    n_vec++;
    if (int'(pos_x) != x || int'(pos_y) != y || step_p || blk_p) begin
      n_err++;
      $display("FAIL %s: got pos=(%0d,%0d) step=%0b blocked=%0b, required pos=(%0d,%0d) step=0 blocked=0",
               name, pos_x, pos_y, step_p, blk_p, x, y);
    end
  endtask

  task automatic tap(input logic [3:0] b, input bit blk, input int x, input int y);
    expect_ev(blk, x, y, 1);
    btn = b;
    tick(1);
    btn = 4'b0;
    tick(2);
  endtask

  task automatic do_respawn();
    respawn = 1'b1;
    tick(1);
    respawn = 1'b0;
    check_quiet("respawn", 320, 448);
    tick(1);
  endtask

  initial begin
    tick(2);
    check_quiet("reset_state", 320, 448);
    reset = 1'b0;
    tick(2);

    // Single tap up from spawn.
    tap(4'b0001, 1'b0, 320, 416);
    do_respawn();

    // Hold right: steps 0, 8, 12, 16, 20 cycles after the press.
    expect_ev(1'b0, 352, 448, 1);
    expect_ev(1'b0, 384, 448, 9);
    expect_ev(1'b0, 416, 448, 13);
    expect_ev(1'b0, 448, 448, 17);
    expect_ev(1'b0, 480, 448, 21);
    btn = 4'b1000;
    tick(21);
    btn = 4'b0;
    tick(3);
    check_quiet("hold_right_end", 480, 448);
    do_respawn();

    // Up+left together: only up moves; left stays masked until re-pressed.
    expect_ev(1'b0, 320, 416, 1);
    btn = 4'b0101;
    tick(3);
    btn = 4'b0100;
    tick(12);
    check_quiet("left_masked", 320, 416);
    btn = 4'b0;
    tick(2);
    tap(4'b0100, 1'b0, 288, 416);

    // Respawn in the middle of a down auto-repeat.
    do_respawn();
    for (int i = 1; i <= 4; i++) tap(4'b0001, 1'b0, 320, 448 - 32 * i);
    expect_ev(1'b0, 320, 352, 1);
    expect_ev(1'b0, 320, 384, 9);
    expect_ev(1'b0, 320, 416, 13);
    btn = 4'b0010;
    tick(14);
    respawn = 1'b1;
    tick(1);
    respawn = 1'b0;
    check_quiet("respawn_mid_repeat", 320, 448);
    tick(15);
    check_quiet("down_masked", 320, 448);
    btn = 4'b0;
    tick(2);
    tap(4'b0010, 1'b1, 320, 448);

    // Walk to the top-right corner, then push against both walls.
    do_respawn();
    for (int i = 1; i <= 14; i++) tap(4'b0001, 1'b0, 320, 448 - 32 * i);
    for (int i = 1; i <= 9; i++)  tap(4'b1000, 1'b0, 320 + 32 * i, 0);
    tap(4'b1000, 1'b1, 608, 0);
    tap(4'b0001, 1'b1, 608, 0);
    check_quiet("corner", 608, 0);

    // Reset during HOLD_REPEAT; right held across release is a fresh press.
    do_respawn();
    expect_ev(1'b0, 352, 448, 1);
    expect_ev(1'b0, 384, 448, 9);
    btn = 4'b1000;
    tick(11);
    reset = 1'b1;
    #1;
    check_quiet("async_reset", 320, 448);
    tick(2);
    reset = 1'b0;
    expect_ev(1'b0, 352, 448, 1);
    tick(1);
    btn = 4'b0;
    tick(4);
    check_quiet("after_reset_press", 352, 448);

    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pulses outstanding, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
